// File: rtl/relobi_fault_monitor.sv
// Fault monitor for reliable-OBI correctors: saturating event counters,
// first-faulting-source capture and OK/ALERT/FATAL escalation.
module relobi_fault_monitor #(
  parameter int unsigned NumSources  = 4,
  parameter int unsigned CntWidth    = 16,
  parameter int unsigned SrcIdxWidth = (NumSources > 1) ? $clog2(NumSources) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumSources-1:0][1:0]         fault_i,
  input  logic [CntWidth-1:0]                threshold_i,
  input  logic                               clear_i,
  output logic [CntWidth-1:0]                corr_cnt_o,
  output logic [CntWidth-1:0]                uncorr_cnt_o,
  output logic                               first_valid_o,
  output logic [SrcIdxWidth-1:0]             first_src_o,
  output logic [1:0]                         state_o,
  output logic                               irq_o,
  output logic                               fatal_o
);

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_ALERT = 2'd1,
    ST_FATAL = 2'd2
  } state_e;

  localparam logic [CntWidth-1:0] CntMax  = {CntWidth{1'b1}};
  localparam logic [CntWidth:0]   CntZero = {(CntWidth+1){1'b0}};

  function automatic logic [CntWidth:0] count_bit(input logic [NumSources-1:0][1:0] f,
                                                   input int unsigned b);
    logic [CntWidth:0] n;
    n = CntZero;
    for (int unsigned i = 0; i < NumSources; i++) begin
      n = n + {{CntWidth{1'b0}}, f[i][b]};
    end
    return n;
  endfunction

  // Sum is formed one bit wider so an overflow pins the counter at all-ones.
  function automatic logic [CntWidth-1:0] sat_add(input logic [CntWidth-1:0] cnt,
                                                  input logic [CntWidth:0]   n);
    logic [CntWidth:0] sum;
    sum = {1'b0, cnt} + n;
    return sum[CntWidth] ? CntMax : sum[CntWidth-1:0];
  endfunction

  logic [NumSources-1:0][1:0] fault_q;
  logic [CntWidth-1:0]        corr_q, corr_d, uncorr_q, uncorr_d;
  logic                       first_valid_q, first_valid_d;
  logic [SrcIdxWidth-1:0]     first_src_q, first_src_d;
  state_e                     state_q, state_d;
  logic                       irq_q, fatal_q;
  logic [CntWidth:0]          nc_s, nu_s;
  logic                       any_s;
  logic [SrcIdxWidth-1:0]     idx_s;

  // Event counts and lowest faulting source from the registered fault vector.
  always_comb begin
    nc_s  = count_bit(fault_q, 0);
    nu_s  = count_bit(fault_q, 1);
    any_s = 1'b0;
    idx_s = {SrcIdxWidth{1'b0}};
    for (int i = NumSources - 1; i >= 0; i--) begin
      if (fault_q[i] != 2'b00) begin
        any_s = 1'b1;
        idx_s = SrcIdxWidth'(i);
      end else begin
        any_s = any_s;
      end
    end
  end

  // Counter, capture and next-state evaluation on the post-update counts.
  always_comb begin
    corr_d        = sat_add(corr_q, nc_s);
    uncorr_d      = sat_add(uncorr_q, nu_s);
    first_valid_d = first_valid_q;
    first_src_d   = first_src_q;
    if (!first_valid_q && any_s) begin
      first_valid_d = 1'b1;
      first_src_d   = idx_s;
    end else begin
      first_valid_d = first_valid_q;
    end
    state_d = state_q;
    case (state_q)
      ST_OK: begin
        if (nu_s != CntZero) begin
          state_d = ST_FATAL;
        end else if ((threshold_i != {CntWidth{1'b0}}) && (corr_d >= threshold_i)) begin
          state_d = ST_ALERT;
        end else begin
          state_d = ST_OK;
        end
      end
      ST_ALERT: begin
        if (nu_s != CntZero) begin
          state_d = ST_FATAL;
        end else begin
          state_d = ST_ALERT;
        end
      end
      ST_FATAL: state_d = ST_FATAL;
      default:  state_d = ST_FATAL;
    endcase
  end

  // State register; clear wins over any event seen in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fault_q       <= {NumSources{2'b00}};
      corr_q        <= {CntWidth{1'b0}};
      uncorr_q      <= {CntWidth{1'b0}};
      first_valid_q <= 1'b0;
      first_src_q   <= {SrcIdxWidth{1'b0}};
      state_q       <= ST_OK;
      irq_q         <= 1'b0;
      fatal_q       <= 1'b0;
    end else begin
      fault_q <= fault_i;
      if (clear_i) begin
        corr_q        <= {CntWidth{1'b0}};
        uncorr_q      <= {CntWidth{1'b0}};
        first_valid_q <= 1'b0;
        first_src_q   <= {SrcIdxWidth{1'b0}};
        state_q       <= ST_OK;
        irq_q         <= 1'b0;
        fatal_q       <= 1'b0;
      end else begin
        corr_q        <= corr_d;
        uncorr_q      <= uncorr_d;
        first_valid_q <= first_valid_d;
        first_src_q   <= first_src_d;
        state_q       <= state_d;
        irq_q         <= (state_d != ST_OK);
        fatal_q       <= (state_d == ST_FATAL);
      end
    end
  end

  assign corr_cnt_o    = corr_q;
  assign uncorr_cnt_o  = uncorr_q;
  assign first_valid_o = first_valid_q;
  assign first_src_o   = first_src_q;
  assign state_o       = state_q;
  assign irq_o         = irq_q;
  assign fatal_o       = fatal_q;

endmodule

// File: tb/tb_relobi_fault_monitor.sv
// Scoreboard bench: the driver predicts each cycle's outputs from the monitor's
// rules and queues them; a negedge monitor compares against the DUT.
module tb_relobi_fault_monitor;

  localparam int NS  = 4;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [NS-1:0][1:0]   fault_i;
  logic [CW-1:0]        threshold_i;
  logic                 clear_i;
  logic [CW-1:0]        corr_cnt_o, uncorr_cnt_o;
  logic                 first_valid_o;
  logic [1:0]           first_src_o;
  logic [1:0]           state_o;
  logic                 irq_o, fatal_o;

  relobi_fault_monitor #(.NumSources(NS), .CntWidth(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .fault_i(fault_i), .threshold_i(threshold_i),
    .clear_i(clear_i), .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o),
    .first_valid_o(first_valid_o), .first_src_o(first_src_o), .state_o(state_o),
    .irq_o(irq_o), .fatal_o(fatal_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int corr; int uncorr; int fv; int fs; int st;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state (spec-level quantities)
  int m_corr, m_uncorr, m_fv, m_fs, m_st;
  logic [NS-1:0][1:0] m_prev;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_corr = 0; m_uncorr = 0; m_fv = 0; m_fs = 0; m_st = 0; m_prev = '0;
  endtask

  // One clock edge as seen by the monitor: events come from last cycle's vector.
  task automatic model_edge(input logic [NS-1:0][1:0] f, input int thr, input bit clr);
    int nc, nu;
    exp_t e;
    if (clr) begin
      m_corr = 0; m_uncorr = 0; m_fv = 0; m_fs = 0; m_st = 0;
    end else begin
      nc = 0; nu = 0;
      for (int i = 0; i < NS; i++) begin
        nc += int'(m_prev[i][0]);
        nu += int'(m_prev[i][1]);
      end
      m_corr   = (m_corr + nc > MAX) ? MAX : m_corr + nc;
      m_uncorr = (m_uncorr + nu > MAX) ? MAX : m_uncorr + nu;
      if (m_fv == 0) begin
        for (int i = NS - 1; i >= 0; i--)
          if (m_prev[i] != 2'b00) begin m_fv = 1; m_fs = i; end
      end
      if (m_st != 2) begin
        if (nu > 0) m_st = 2;
        else if (m_st == 0 && thr != 0 && m_corr >= thr) m_st = 1;
      end
    end
    m_prev = f;
    e.corr = m_corr; e.uncorr = m_uncorr; e.fv = m_fv; e.fs = m_fs; e.st = m_st;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [NS-1:0][1:0] f, input int thr, input bit clr);
    fault_i = f; threshold_i = CW'(thr); clear_i = clr;
    @(posedge clk_i);
    model_edge(f, thr, clr);
    #1;
  endtask

  function automatic logic [NS-1:0][1:0] one_src(input int idx, input logic [1:0] p);
    logic [NS-1:0][1:0] v;
    v = '0;
    v[idx] = p;
    return v;
  endfunction

  // Monitor: every cycle the DUT presents a fresh output set.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("corr_cnt",    int'(corr_cnt_o),    e.corr);
        chk("uncorr_cnt",  int'(uncorr_cnt_o),  e.uncorr);
        chk("first_valid", int'(first_valid_o), e.fv);
        chk("first_src",   int'(first_src_o),   e.fs);
        chk("state",       int'(state_o),       e.st);
        chk("irq",         int'(irq_o),         (e.st != 0) ? 1 : 0);
        chk("fatal",       int'(fatal_o),       (e.st == 2) ? 1 : 0);
      end
    end
  end

  initial begin
    logic [NS-1:0][1:0] f;
    int thr, p;
    rst_ni = 1'b0; fault_i = '0; threshold_i = '0; clear_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_state", int'(state_o), 0);
    chk("reset_corr", int'(corr_cnt_o), 0);
    rst_ni = 1'b1;

    // Single corrected fault on source 2
    step(one_src(2, 2'b01), 3, 1'b0);
    step('0, 3, 1'b0);
    chk("t1_corr", int'(corr_cnt_o), 1);
    chk("t1_first_src", int'(first_src_o), 2);
    chk("t1_irq", int'(irq_o), 0);

    // Sources 0 and 1 for two cycles, threshold 3 -> ALERT at count 4
    step('0, 3, 1'b1);
    step(8'b0000_0101, 3, 1'b0);
    step(8'b0000_0101, 3, 1'b0);
    step('0, 3, 1'b0);
    chk("t2_alert", int'(state_o), 1);
    step('0, 1, 1'b0);

    // Uncorrectable on source 3 -> FATAL, sticky
    step(one_src(3, 2'b11), 1, 1'b0);
    repeat (3) step('0, 1, 1'b0);
    chk("t3_fatal", int'(fatal_o), 1);

    // Saturation: all sources corrected for five cycles
    step('0, 0, 1'b1);
    repeat (5) step(8'b0101_0101, 0, 1'b0);
    step('0, 0, 1'b0);
    chk("t4_sat", int'(corr_cnt_o), MAX);

    // Clear while source 1 event sits in the input register
    step(one_src(1, 2'b01), 0, 1'b0);
    step(one_src(0, 2'b01), 0, 1'b1);
    step('0, 0, 1'b0);
    step('0, 0, 1'b0);
    chk("t5_after_clear", int'(corr_cnt_o), 1);

    // Asynchronous reset while FATAL
    step(one_src(3, 2'b10), 0, 1'b0);
    step('0, 0, 1'b0);
    #2;
    rst_ni = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    chk("arst_fatal", int'(fatal_o), 0);
    chk("arst_irq", int'(irq_o), 0);
    chk("arst_uncorr", int'(uncorr_cnt_o), 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Randomized traffic; threshold only changes on clear cycles
    thr = 5;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NS; i++) begin
        p = $urandom_range(0, 19);
        f[i] = (p < 3) ? 2'b01 : (p == 3) ? 2'b10 : (p == 4) ? 2'b11 : 2'b00;
      end
      if ($urandom_range(0, 14) == 0) begin
        thr = $urandom_range(0, MAX);
        step(f, thr, 1'b1);
      end else begin
        step(f, thr, 1'b0);
      end
    end
    step('0, thr, 1'b0);
    @(negedge clk_i);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/relobi_fault_monitor.md
# relobi_fault_monitor

Sequential fault monitor and escalation controller for the reliable-OBI corrector datapath. It collects the 2-bit `fault_o` vectors of up to `NumSources` relobi correctors (bit 0 = corrected/voter fault, bit 1 = uncorrectable ECC fault). It keeps saturating event counters and records the first faulting source. It escalates through an OK / ALERT / FATAL state machine that drives an interrupt and a fatal-stop signal towards the system controller. It sits beside the interconnect, one instance per reliable-OBI domain, and is cleared by software.

## Interface
Parameters:
- `NumSources`, default 4: number of corrector fault vectors monitored; must be ≥ 1.
- `CntWidth`, default 16: width of each event counter.
- `SrcIdxWidth`, default `NumSources > 1 ? $clog2(NumSources) : 1`: width of the source index. Derived; do not override.

Ports:
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `fault_i`, input, [NumSources-1:0][1:0]: per-source fault flags, each pair taken directly from a corrector `fault_o`.
- `threshold_i`, input, CntWidth: corrected-event count at which ALERT is entered. The value 0 disables ALERT.
- `clear_i`, input, 1: single-cycle pulse that clears counters, first-source capture and state.
- `corr_cnt_o`, output, CntWidth: saturating count of corrected events.
- `uncorr_cnt_o`, output, CntWidth: saturating count of uncorrectable events.
- `first_valid_o`, output, 1: `first_src_o` holds a captured value.
- `first_src_o`, output, SrcIdxWidth: index of the first source that faulted since reset or clear.
- `state_o`, output, 2: current state; 0 = OK, 1 = ALERT, 2 = FATAL.
- `irq_o`, output, 1: high while the state is not OK.
- `fatal_o`, output, 1: high while the state is FATAL.

## Operation
Input stage:
- `fault_i` is registered into `fault_q` every cycle, including cycles where `clear_i` is high.
- All bookkeeping uses `fault_q`.

Event counting (per cycle, from `fault_q`):
- `nc` = popcount of bit 0 over all sources.
- `nu` = popcount of bit 1 over all sources.
- A source with both bits set contributes to both counts.
- The counters compute `cnt + n` at width CntWidth+1. If the sum exceeds 2^CntWidth−1, the counter saturates at all-ones and holds.

First-source capture:
- Applies only while `first_valid_o` = 0 and some source in `fault_q` has a nonzero pair.
- `first_src_o` ← lowest such index, and `first_valid_o` ← 1.
- Both then hold until clear or reset.

State machine (next-state evaluated on the post-update counter values):
- OK → FATAL if `nu` > 0.
- OK → ALERT if `threshold_i` ≠ 0 and the new `corr_cnt` ≥ `threshold_i`.
- ALERT → FATAL if `nu` > 0. Otherwise ALERT holds; a later decrease of `threshold_i` does not return the state to OK.
- FATAL is sticky. Only `clear_i` or reset leaves it.
- FATAL has priority over ALERT in the same cycle. OK can go directly to FATAL.
- Encoding 3 is unreachable. If it is ever reached, it is treated as FATAL.

Clear:
- When `clear_i` = 1, all counters go to 0, `first_valid_o` and `first_src_o` go to 0, and the state goes to OK.
- Clear has priority: events in `fault_q` during the clear cycle are discarded.
- Events registered on the clear edge itself are counted in the following cycle.

Outputs:
- All outputs are registered. There is no combinational path from any input to any output.
- `irq_o` = (state ≠ OK); `fatal_o` = (state == FATAL). Both are derived from the state register.

## Timing
- Latency: a fault on `fault_i` sampled at edge t updates the counters, `first_src_o` and `state_o`/`irq_o`/`fatal_o` at edge t+1. It is visible after edge t+1, two cycles after it is presented.
- Clear latency: `clear_i` sampled at edge t gives all outputs at their reset values after edge t.
- `threshold_i` is sampled combinationally at the update edge; it must be quasi-static.
- Reset (asynchronous, active-low): `fault_q` = 0, counters = 0, `first_valid_o` = 0, `first_src_o` = 0, state = OK, `irq_o` = 0, `fatal_o` = 0.
- Reset asserted mid-escalation returns to OK immediately, with no dependency on the clock. The first edge after deassertion samples `fault_i` normally.
- The monitor exerts no backpressure and never drops an event, except during a clear cycle or after saturation.

## Test plan
- Reset, then `fault_i[2]` = 2'b01 for one cycle with `threshold_i` = 3: after two cycles `corr_cnt_o` = 1, `first_valid_o` = 1, `first_src_o` = 2, `state_o` = OK, `irq_o` = 0.
- `threshold_i` = 3, then sources 0 and 1 both at 2'b01 for two cycles: `corr_cnt_o` = 2, then 4; ALERT and `irq_o` = 1 appear in the cycle the count reaches 4; `first_src_o` = 0.
- In ALERT, `fault_i[3]` = 2'b11 for one cycle: `corr_cnt_o` +1, `uncorr_cnt_o` = 1, `state_o` = FATAL, `fatal_o` = 1; the state stays FATAL with no further faults.
- `CntWidth` = 4, `NumSources` = 4, all sources at 2'b01 for five cycles: the count goes 4, 8, 12, 15, 15 (saturated).
- `clear_i` pulsed while `fault_q` holds 2'b01 on source 1: all outputs return to 0/OK; that event is not counted; an event applied on the clear edge is counted one cycle later.
- `rst_ni` asserted asynchronously between edges while in FATAL: `fatal_o`, `irq_o` and the counters are 0 before the next clock edge.
